// File: rtl/ram256x16_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram256x16_fifo_ctrl                                           |
// | Purpose  : Runs one 256x16 block RAM as a first-word-fall-through FIFO.  |
// |            Owns the RAM write/read ports, the pointers and occupancy,    |
// |            and hides the one-cycle RAM read latency behind a 2-entry     |
// |            output buffer so both sides can stream one word per cycle.    |
// | Ports    : clk_i, rstn_i (async, active low)                             |
// |            in_data_i/in_valid_i/in_ready_o     : write stream            |
// |            out_data_o/out_valid_o/out_ready_i  : read stream             |
// |            level_o                             : words held (0..258)     |
// |            ram_waddr_o/ram_wdata_o/ram_we_o    : RAM write port          |
// |            ram_raddr_o/ram_re_o/ram_rdata_i    : RAM read port           |
// |            clear_i (only with RAM256X16_FIFO_CTRL_CLEAR_EN)              |
// | Options  : RAM256X16_FIFO_CTRL_CLEAR_EN adds a synchronous clear input.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ram256x16_fifo_ctrl (
  input  logic        clk_i,
  input  logic        rstn_i,
`ifdef RAM256X16_FIFO_CTRL_CLEAR_EN
  input  logic        clear_i,
`endif
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [8:0]  level_o,
  output logic [7:0]  ram_waddr_o,
  output logic [15:0] ram_wdata_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_raddr_o,
  output logic        ram_re_o,
  input  logic [15:0] ram_rdata_i
);

  localparam logic [8:0] RAM_DEPTH = 9'd256;

  logic [7:0]  wptr_q, wptr_d;
  logic [7:0]  rptr_q, rptr_d;
  logic [8:0]  ram_cnt_q, ram_cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  obuf_cnt_q, obuf_cnt_d;
  logic [15:0] obuf0_q, obuf0_d;   // buffer head, drives out_data_o
  logic [15:0] obuf1_q, obuf1_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [8:0]  level_q, level_d;

  logic        clr_w;
  logic        wr_w;
  logic        pop_w;
  logic        issue_w;
  logic [2:0]  occ_w;
  logic [1:0]  slot_w;

`ifdef RAM256X16_FIFO_CTRL_CLEAR_EN
  assign clr_w = clear_i;
`else
  assign clr_w = 1'b0;
`endif

  // A clear cycle refuses writes and discards any pop.
  assign in_ready_o  = in_ready_q & ~clr_w;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = obuf0_q;
  assign level_o     = level_q;

  assign wr_w  = in_valid_i & in_ready_o;
  assign pop_w = out_valid_q & out_ready_i & ~clr_w;

  // Buffer entries already committed (held + in flight). A read may be
  // issued only if, after this cycle's pop, there is room for its data.
  assign occ_w   = {1'b0, obuf_cnt_q} + {2'b00, pend_q};
  assign issue_w = (ram_cnt_q != 9'd0) && ~clr_w &&
                   (occ_w < (pop_w ? 3'd3 : 3'd2));

  // RAM strobes are gated by reset directly so they are low the moment
  // rstn_i falls, not only after the registers settle.
  assign ram_we_o    = wr_w & rstn_i;
  assign ram_waddr_o = wptr_q;
  assign ram_wdata_o = in_data_i;
  assign ram_re_o    = issue_w & rstn_i;
  assign ram_raddr_o = rptr_q;

  // Slot the captured word lands in, after this cycle's pop has shifted.
  assign slot_w = obuf_cnt_q - {1'b0, pop_w};

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ram_cnt_d   = ram_cnt_q;
    pend_d      = pend_q;
    obuf_cnt_d  = obuf_cnt_q;
    obuf0_d     = obuf0_q;
    obuf1_d     = obuf1_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    level_d     = level_q;

    if (clr_w) begin
      // Everything empties; the head register keeps its last value.
      wptr_d      = 8'd0;
      rptr_d      = 8'd0;
      ram_cnt_d   = 9'd0;
      pend_d      = 1'b0;
      obuf_cnt_d  = 2'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      level_d     = 9'd0;
    end else begin
      if (wr_w)    wptr_d = wptr_q + 8'd1;
      if (issue_w) rptr_d = rptr_q + 8'd1;
      ram_cnt_d = ram_cnt_q + {8'd0, wr_w} - {8'd0, issue_w};
      pend_d    = issue_w;

      // Shift only when a second entry exists; an emptied buffer keeps
      // presenting the last word.
      if (pop_w && (obuf_cnt_q == 2'd2)) obuf0_d = obuf1_q;
      if (pend_q) begin
        if (slot_w == 2'd0) obuf0_d = ram_rdata_i;
        else                obuf1_d = ram_rdata_i;
      end
      obuf_cnt_d = obuf_cnt_q - {1'b0, pop_w} + {1'b0, pend_q};

      in_ready_d  = (ram_cnt_d != RAM_DEPTH);
      out_valid_d = (obuf_cnt_d != 2'd0);
      level_d     = ram_cnt_d + {8'd0, pend_d} + {7'd0, obuf_cnt_d};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q      <= 8'd0;
      rptr_q      <= 8'd0;
      ram_cnt_q   <= 9'd0;
      pend_q      <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      obuf0_q     <= 16'd0;
      obuf1_q     <= 16'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      level_q     <= 9'd0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_cnt_q   <= ram_cnt_d;
      pend_q      <= pend_d;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf0_q     <= obuf0_d;
      obuf1_q     <= obuf1_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram256x16_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram256x16_fifo_ctrl                                        |
// | Purpose  : Self-checking bench for ram256x16_fifo_ctrl. A queue model    |
// |            holds every accepted word; a 256x16 RAM model is attached to |
// |            the RAM ports. Build with RAM256X16_FIFO_CTRL_CLEAR_EN to     |
// |            also exercise clear_i.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ram256x16_fifo_ctrl;

  logic        clk;
  logic        rstn_i;
  logic        clear_i;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [8:0]  level_o;
  logic [7:0]  ram_waddr_o;
  logic [15:0] ram_wdata_o;
  logic        ram_we_o;
  logic [7:0]  ram_raddr_o;
  logic        ram_re_o;
  logic [15:0] ram_rdata_i;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];          // reference: every word held, oldest first
  logic [15:0] mem [0:255];   // block RAM model

  ram256x16_fifo_ctrl dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
`ifdef RAM256X16_FIFO_CTRL_CLEAR_EN
    .clear_i     (clear_i),
`endif
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .level_o     (level_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_re_o    (ram_re_o),
    .ram_rdata_i (ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: RDATA valid the cycle after the read edge, old data on collision.
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
    if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
  end

  // Scoreboard: handshakes sampled before the edge, state checked 1 ns after.
  int wait_cnt = 0;
  always @(posedge clk) begin : mon
    logic        stall;
    logic [15:0] sdata;
    logic [15:0] exp_w;
    if (!rstn_i || clear_i) begin
      q.delete();
      wait_cnt = 0;
    end else begin
      stall = out_valid_o && !out_ready_i;
      sdata = out_data_o;
      checks++;
      if (ram_we_o !== (in_valid_i & in_ready_o)) begin
        errors++;
        $display("FAIL ram_we: got %0b expected %0b", ram_we_o, in_valid_i & in_ready_o);
      end
      if (ram_we_o) begin
        checks++;
        if (ram_wdata_o !== in_data_i) begin
          errors++;
          $display("FAIL ram_wdata: got %04h expected %04h", ram_wdata_o, in_data_i);
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty: got pop of %04h expected no valid word", out_data_o);
        end else begin
          exp_w = q.pop_front();
          if (out_data_o !== exp_w) begin
            errors++;
            $display("FAIL pop_data: got %04h expected %04h", out_data_o, exp_w);
          end
        end
      end
      if (in_valid_i && in_ready_o) q.push_back(in_data_i);
      #1;
      checks++;
      if (level_o !== 9'(q.size())) begin
        errors++;
        $display("FAIL level: got %0d expected %0d", level_o, q.size());
      end
      if (out_valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL valid_empty: got valid=1 expected valid=0");
        end else if (out_data_o !== q[0]) begin
          errors++;
          $display("FAIL head: got %04h expected %04h", out_data_o, q[0]);
        end
      end
      if (stall) begin
        checks++;
        if (!out_valid_o || out_data_o !== sdata) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%04h expected v=1 d=%04h",
                   out_valid_o, out_data_o, sdata);
        end
      end
      if (q.size() < 256) begin
        checks++;
        if (in_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL in_ready_room: got %0b expected 1 (held %0d)", in_ready_o, q.size());
        end
      end else if (q.size() >= 258) begin
        checks++;
        if (in_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_full: got %0b expected 0", in_ready_o);
        end
      end
      if (q.size() > 0 && !out_valid_o) wait_cnt++;
      else wait_cnt = 0;
      if (wait_cnt > 2) begin
        checks++;
        errors++;
        $display("FAIL latency: got %0d cycles without valid expected <= 2", wait_cnt);
        wait_cnt = 0;
      end
    end
  end

  task automatic test_reset;
    #12;
    checks += 6;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", out_valid_o); end
    if (out_data_o !== 16'h0) begin errors++; $display("FAIL rst_data: got %04h expected 0000", out_data_o); end
    if (level_o !== 9'd0)     begin errors++; $display("FAIL rst_level: got %0d expected 0", level_o); end
    if (in_ready_o !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %0b expected 0", in_ready_o); end
    if (ram_we_o !== 1'b0)    begin errors++; $display("FAIL rst_we: got %0b expected 0", ram_we_o); end
    if (ram_re_o !== 1'b0)    begin errors++; $display("FAIL rst_re: got %0b expected 0", ram_re_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rel_ready_pre: got %0b expected 0", in_ready_o); end
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rel_ready_post: got %0b expected 1", in_ready_o); end
  endtask

  task automatic test_single_word;
    @(negedge clk);
    in_data_i = 16'h1234; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    checks += 2;
    if (level_o !== 9'd1)     begin errors++; $display("FAIL sw_level_e0: got %0d expected 1", level_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL sw_valid_e0: got %0b expected 0", out_valid_o); end
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL sw_valid_e1: got %0b expected 0", out_valid_o); end
    @(negedge clk);
    checks += 3;
    if (out_valid_o !== 1'b1)    begin errors++; $display("FAIL sw_valid_e2: got %0b expected 1", out_valid_o); end
    if (out_data_o !== 16'h1234) begin errors++; $display("FAIL sw_data: got %04h expected 1234", out_data_o); end
    if (level_o !== 9'd1)        begin errors++; $display("FAIL sw_level_e2: got %0d expected 1", level_o); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    checks += 3;
    if (level_o !== 9'd0)        begin errors++; $display("FAIL sw_level_pop: got %0d expected 0", level_o); end
    if (out_valid_o !== 1'b0)    begin errors++; $display("FAIL sw_valid_pop: got %0b expected 0", out_valid_o); end
    if (out_data_o !== 16'h1234) begin errors++; $display("FAIL sw_hold: got %04h expected 1234", out_data_o); end
  endtask

  task automatic test_fill_drain;
    int nxt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_data_i = 16'(nxt); in_valid_i = 1'b1;
      if (in_ready_o) nxt++;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    checks += 3;
    if (nxt != 258)          begin errors++; $display("FAIL fill_count: got %0d expected 258", nxt); end
    if (level_o !== 9'd258)  begin errors++; $display("FAIL fill_level: got %0d expected 258", level_o); end
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b expected 0", in_ready_o); end
    for (int i = 0; i < 258; i++) begin
      @(negedge clk);
      out_ready_i = 1'b1;
      if (i == 1) begin
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready: got %0b expected 1", in_ready_o); end
      end
      checks++;
      if (!out_valid_o || out_data_o !== 16'(i)) begin
        errors++;
        $display("FAIL drain_word: got v=%0b d=%04h expected v=1 d=%04h", out_valid_o, out_data_o, i);
      end
    end
    @(negedge clk);
    out_ready_i = 1'b0;
    checks += 2;
    if (level_o !== 9'd0)     begin errors++; $display("FAIL drain_level: got %0d expected 0", level_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b expected 0", out_valid_o); end
  endtask

  task automatic test_stream;
    int sent = 0;
    int bubbles = 0;
    int cyc = 0;
    bit seen = 0;
    out_ready_i = 1'b1;
    while ((sent < 1000 || q.size() > 0) && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (out_valid_o) seen = 1;
      else if (seen && q.size() > 0) bubbles++;
      if (sent < 1000) begin
        in_data_i = 16'($urandom); in_valid_i = 1'b1;
        if (in_ready_o) sent++;
      end else begin
        in_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    checks += 3;
    if (sent != 1000) begin errors++; $display("FAIL stream_sent: got %0d expected 1000", sent); end
    if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d expected 0", bubbles); end
    if (q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left expected 0", q.size()); end
  endtask

  task automatic test_backpressure;
    int wr = 0;
    int rd = 0;
    int cyc = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_data_i   = 16'($urandom);
      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = ($urandom_range(0, 3) == 0);
      if (in_valid_i && in_ready_o) wr++;
      if (out_valid_o && out_ready_i) rd++;
    end
    in_valid_i = 1'b0;
    while (q.size() > 0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      out_ready_i = 1'b1;
      if (out_valid_o) rd++;
    end
    @(negedge clk);
    out_ready_i = 1'b0;
    checks += 2;
    if (rd != wr)         begin errors++; $display("FAIL bp_count: got %0d out expected %0d", rd, wr); end
    if (level_o !== 9'd0) begin errors++; $display("FAIL bp_level: got %0d expected 0", level_o); end
  endtask

  // Leaves the FIFO with a read in flight (issued at the last edge).
  task automatic start_inflight(output bit found);
    found = 0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      in_data_i = 16'($urandom); in_valid_i = 1'b1;
      #1;
      if (ram_re_o) found = 1;
    end
    @(posedge clk);
    checks++;
    if (!found) begin errors++; $display("FAIL inflight_setup: got no read issue expected one"); end
  endtask

  task automatic expect_first_word(input logic [15:0] w, input string tag);
    int cyc = 0;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready: got %0b expected 1", tag, in_ready_o); end
    in_data_i = w; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    while (!out_valid_o && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks += 2;
    if (out_data_o !== w || !out_valid_o) begin
      errors++;
      $display("FAIL %s_first: got v=%0b d=%04h expected v=1 d=%04h", tag, out_valid_o, out_data_o, w);
    end
    if (level_o !== 9'd1) begin errors++; $display("FAIL %s_level: got %0d expected 1", tag, level_o); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit found;
    start_inflight(found);
    #3 rstn_i = 1'b0;
    #1;
    checks += 5;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", out_valid_o); end
    if (out_data_o !== 16'h0) begin errors++; $display("FAIL mid_data: got %04h expected 0000", out_data_o); end
    if (level_o !== 9'd0)     begin errors++; $display("FAIL mid_level: got %0d expected 0", level_o); end
    if (in_ready_o !== 1'b0)  begin errors++; $display("FAIL mid_ready: got %0b expected 0", in_ready_o); end
    if ((ram_we_o | ram_re_o) !== 1'b0) begin
      errors++; $display("FAIL mid_strobes: got we=%0b re=%0b expected 0", ram_we_o, ram_re_o);
    end
    repeat (2) @(negedge clk);
    in_valid_i = 1'b0;
    rstn_i = 1'b1;
    @(posedge clk);
    expect_first_word(16'hBEEF, "mid");
  endtask

`ifdef RAM256X16_FIFO_CTRL_CLEAR_EN
  task automatic test_clear;
    bit found;
    start_inflight(found);
    @(negedge clk);
    clear_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    checks += 2;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL clr_ready: got %0b expected 0", in_ready_o); end
    if (ram_we_o !== 1'b0)   begin errors++; $display("FAIL clr_we: got %0b expected 0", ram_we_o); end
    @(negedge clk);
    clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    checks += 3;
    if (level_o !== 9'd0)     begin errors++; $display("FAIL clr_level: got %0d expected 0", level_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b expected 0", out_valid_o); end
    if (in_ready_o !== 1'b1)  begin errors++; $display("FAIL clr_ready_after: got %0b expected 1", in_ready_o); end
    expect_first_word(16'hCAFE, "clr");
  endtask
`endif

  initial begin
    rstn_i = 1'b0; clear_i = 1'b0;
    in_data_i = 16'h0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    test_reset();
    test_single_word();
    test_fill_drain();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef RAM256X16_FIFO_CTRL_CLEAR_EN
    test_clear();
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
